// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store controller driving a req/ack data memory
// Ports:
//   clk_i, start_i (sync active-low reset)
//   MemRead_i, MemWrite_i, funct3_i, ALUResult_i, MemWriteData_i : EX_MEM access request
//   DataMemReadData_o : formatted load data for MEM_WB
//   stall_o, err_o    : pipeline freeze and access fault (combinational)
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o : registered memory request
//   mem_ack_i, mem_rdata_i : memory completion and read word
module data_mem_ctrl #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] MemWriteData_i,
    output logic [31:0] DataMemReadData_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic        r_req, r_we, r_to;
    logic [3:0]  r_be;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;
    logic        w_op, w_bad, w_f3_bad, w_align_bad, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shift, w_load;

    assign w_op = MemRead_i | MemWrite_i;
    assign w_f3_bad = MemWrite_i ? (funct3_i[2] | (&funct3_i[1:0]))
                                 : (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11);
    assign w_align_bad = (funct3_i[1:0] == 2'b10 && ALUResult_i[1:0] != 2'b00) ||
                         (funct3_i[1:0] == 2'b01 && ALUResult_i[0]);
    assign w_bad = (MemRead_i & MemWrite_i) | w_f3_bad | w_align_bad;
    assign w_be = funct3_i[1:0] == 2'b00 ? 4'b0001 << ALUResult_i[1:0] :
                  funct3_i[1:0] == 2'b01 ? (ALUResult_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = funct3_i[1:0] == 2'b00 ? {4{MemWriteData_i[7:0]}} :
                     funct3_i[1:0] == 2'b01 ? {2{MemWriteData_i[15:0]}} : MemWriteData_i;
    // Bring the addressed lane down to bit 0, then extend per the captured funct3
    assign w_shift = mem_rdata_i >> {r_off, 3'b000};
    assign w_load = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_shift[7]}}, w_shift[7:0]} :
                    r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]} : mem_rdata_i;
    // r_cnt holds the number of completed REQ cycles, so the last allowed one sees ACK_TIMEOUT-1
    assign w_timeout = r_cnt == 8'(ACK_TIMEOUT - 1);

    always_ff @(posedge clk_i) begin
        if (!start_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        err_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                err_o   = w_op & w_bad;
                stall_o = w_op & ~w_bad;
                w_next  = (w_op & ~w_bad) ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                stall_o = 1'b1;
                w_next  = (mem_ack_i | w_timeout) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                err_o  = r_to;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_to    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_op && w_bad && MemRead_i) r_rdata <= '0;
                    if (w_op && !w_bad) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_i;
                        r_addr  <= {ALUResult_i[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_f3    <= funct3_i;
                        r_off   <= ALUResult_i[1:0];
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        r_req <= 1'b0;
                        if (!r_we) r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                        r_to  <= 1'b1;
                        if (!r_we) r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: r_to <= 1'b0;
                default: ;
            endcase
        end
    end

    assign DataMemReadData_o = r_rdata;
    assign mem_req_o         = r_req;
    assign mem_we_o          = r_we;
    assign mem_addr_o        = r_addr;
    assign mem_be_o          = r_be;
    assign mem_wdata_o       = r_wdata;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed plus randomized checking of data_mem_ctrl against a byte-level model
module tb_data_mem_ctrl;
    localparam int TO = 4;
    logic        clk = 1'b0, start_i = 1'b0, rd = 1'b0, wr = 1'b0, ack = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0, wd = '0, rdat = '0;
    logic [31:0] dmrd, m_addr, m_wdata;
    logic        stall, err, m_req, m_we;
    logic [3:0]  m_be;
    int          tests = 0, fails = 0;
    logic [31:0] exp_rd = '0;

    data_mem_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk_i(clk), .start_i(start_i), .MemRead_i(rd), .MemWrite_i(wr), .funct3_i(f3),
        .ALUResult_i(addr), .MemWriteData_i(wd), .DataMemReadData_o(dmrd), .stall_o(stall),
        .err_o(err), .mem_req_o(m_req), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_be_o(m_be),
        .mem_wdata_o(m_wdata), .mem_ack_i(ack), .mem_rdata_i(rdat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(bit r, bit w, logic [2:0] f, logic [31:0] a);
        int sz;
        if (r && w) return 1'b1;
        if (w && f > 3'd2) return 1'b1;
        if (r && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
        sz = 1 << f[1:0];
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] load_val(logic [2:0] f, logic [31:0] a, logic [31:0] d);
        int sz = 1 << f[1:0];
        int off = a % 4;
        longint v, m;
        if (sz == 4) return d;
        v = longint'(d) >> (8 * off);
        m = (longint'(1) << (8 * sz)) - 1;
        v = v & m;
        if (!f[2] && v >= (m + 1) / 2) v = v - (m + 1);
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(logic [2:0] f, logic [31:0] a);
        int sz = 1 << f[1:0];
        int v = ((1 << sz) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(logic [2:0] f, logic [31:0] d);
        if (f[1:0] == 2'b00) return {24'd0, d[7:0]} * 32'h01010101;
        if (f[1:0] == 2'b01) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    // Called #1 after a rising edge with the controller idle; returns #1 after the edge leaving DONE.
    // ackn: REQ cycle carrying the ack (0 or > TO means never)
    task automatic run_op(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rdata, input int ackn);
        bit bad, timed, fin;
        rd = r; wr = w; f3 = f; addr = a; wd = d;
        bad = is_bad(r, w, f, a);
        timed = !(ackn >= 1 && ackn <= TO);
        #3;
        if (bad) begin
            chk("bad_err", {31'd0, err}, 32'd1);
            chk("bad_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            if (r) exp_rd = '0;
            chk("bad_req", {31'd0, m_req}, 32'd0);
            chk("bad_rdata", dmrd, exp_rd);
            rd = 1'b0; wr = 1'b0;
            return;
        end
        chk("c0_stall", {31'd0, stall}, 32'd1);
        chk("c0_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        for (int c = 1; c <= TO; c++) begin
            chk("req_hi", {31'd0, m_req}, 32'd1);
            chk("req_stall", {31'd0, stall}, 32'd1);
            chk("we", {31'd0, m_we}, {31'd0, w});
            chk("addr", m_addr, {a[31:2], 2'b00});
            chk("be", {28'd0, m_be}, {28'd0, exp_be(f, a)});
            if (w) chk("wdata", m_wdata, exp_wd(f, d));
            fin = (c == ackn) || (c == TO);
            if (c == ackn) begin ack = 1'b1; rdat = rdata; end
            else rdat = $urandom;
            @(posedge clk); #1;
            ack = 1'b0;
            if (fin) break;
        end
        if (r) exp_rd = timed ? 32'd0 : load_val(f, a, rdata);
        #2;
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_err", {31'd0, err}, {31'd0, timed});
        chk("done_req", {31'd0, m_req}, 32'd0);
        chk("done_rdata", dmrd, exp_rd);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", dmrd, 32'd0);
        chk("rst_req", {31'd0, m_req}, 32'd0);
        chk("rst_we", {31'd0, m_we}, 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_be", {28'd0, m_be}, 32'd0);
        chk("rst_wdata", m_wdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        start_i = 1'b1;
        @(posedge clk); #1;
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        chk("lw_val", dmrd, 32'hDEADBEEF);
        run_op(0, 1, 3'b000, 32'h103, 32'hA5, 32'h0, 2);
        run_op(1, 0, 3'b000, 32'h100, 32'h0, 32'h80F17F80, 1);
        chk("lb_val", dmrd, 32'hFFFFFF80);
        run_op(1, 0, 3'b100, 32'h101, 32'h0, 32'h80F17F80, 3);
        chk("lbu_val", dmrd, 32'h0000007F);
        run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h80F17F80, 1);
        chk("lhu_val", dmrd, 32'h000080F1);
        run_op(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 1);
        run_op(0, 1, 3'b010, 32'h104, 32'h1234, 32'h0, 1);
        run_op(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1);
        run_op(1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 0);
        run_op(1, 0, 3'b001, 32'h202, 32'h0, 32'h1234ABCD, TO);
        chk("ack_at_limit", dmrd, 32'h00001234);
        #3;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        // reset while a request is outstanding
        rd = 1'b1; f3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        chk("rr_req", {31'd0, m_req}, 32'd1);
        @(posedge clk); #1;
        start_i = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1;
        exp_rd = '0;
        chk("rr_req0", {31'd0, m_req}, 32'd0);
        chk("rr_stall", {31'd0, stall}, 32'd0);
        chk("rr_addr", m_addr, 32'd0);
        chk("rr_be", {28'd0, m_be}, 32'd0);
        chk("rr_rdata", dmrd, 32'd0);
        repeat (6) @(posedge clk);
        #1; ack = 1'b1; rdat = 32'hCAFEF00D;
        @(posedge clk); #1; ack = 1'b0;
        chk("late_ack_req", {31'd0, m_req}, 32'd0);
        chk("late_ack_rdata", dmrd, 32'd0);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, 9);
            run_op(k < 5 || k == 9, k >= 5, 3'($urandom_range(0, 7)),
                   32'h1000 + 32'($urandom_range(0, 255)), $urandom, $urandom, $urandom_range(0, TO + 1));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

MEM-stage data-memory access controller between the EX_MEM pipeline register and MEM_WB. It converts a load/store in the MEM stage into a req/ack transaction on a variable-latency data memory. It generates byte enables and store-lane replication, and sign- or zero-extends load data onto the value MEM_WB captures as its read-data input. It stalls the pipeline until the access completes, and flags misaligned or illegal accesses and memory timeouts.

## Interface
- ACK_TIMEOUT, 16: REQ-state cycles without `mem_ack_i` before the access is aborted; range 1..255.
- clk_i  in  1  single clock, rising edge
- start_i  in  1  **synchronous, active-low reset**; sampled only on `clk_i` rising edge
- MemRead_i  in  1  load in MEM stage (from EX_MEM)
- MemWrite_i  in  1  store in MEM stage (from EX_MEM)
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
- ALUResult_i  in  32  effective byte address
- MemWriteData_i  in  32  store data (rs2)
- DataMemReadData_o  out  32  formatted load data; feeds the MEM_WB read-data input
- stall_o  out  1  freezes PC, IF_ID, ID_EX, EX_MEM; combinational
- err_o  out  1  access fault (misaligned, illegal, or timeout); combinational
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  1 = write, registered
- mem_addr_o  out  32  word address {addr[31:2],2'b00}, registered
- mem_be_o  out  4  byte enables, registered
- mem_wdata_o  out  32  lane-replicated store data, registered
- mem_ack_i  in  1  memory completion; read data valid in the same cycle
- mem_rdata_i  in  32  word read data

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- **op** = MemRead_i | MemWrite_i.
- **bad**, evaluated in IDLE, is true when any of the following holds:
  - MemRead_i and MemWrite_i are both high.
  - funct3_i is illegal for the operation (load: 011/110/111; store: anything other than 000/001/010).
  - W access with addr[1:0] ≠ 0.
  - H/HU access with addr[0] ≠ 0.
- IDLE, op & bad:
  - err_o = 1, stall_o = 0, no request.
  - For a load, DataMemReadData_o ← 0.
  - Stay in IDLE.
- IDLE, op & !bad:
  - stall_o = 1.
  - Register mem_addr_o, mem_we_o = MemWrite_i, mem_be_o and mem_wdata_o.
  - Set mem_req_o ← 1, clear the timeout counter, go to REQ.
- Byte enables:
  - B/BU: 1 << addr[1:0].
  - H/HU: addr[1] ? 1100 : 0011.
  - W: 1111.
- Store data replication:
  - SB: {4{wd[7:0]}}.
  - SH: {2{wd[15:0]}}.
  - SW: wd.
- REQ:
  - stall_o = 1 and all memory outputs are held stable.
  - On mem_ack_i:
    - mem_req_o ← 0, go to DONE.
    - For a load, DataMemReadData_o ← the lane at addr[1:0] (B/H) or the full word, extended by funct3 (B/H sign-extend, BU/HU zero-extend).
    - For a store, DataMemReadData_o holds its value.
  - If the counter reaches ACK_TIMEOUT without ack:
    - mem_req_o ← 0 and the timeout flag ← 1.
    - For a load, DataMemReadData_o ← 0.
    - Go to DONE.
- DONE:
  - stall_o = 0 and err_o = timeout flag.
  - Inputs are ignored, so the same instruction is not retriggered.
  - Go to IDLE unconditionally and clear the timeout flag.
- IDLE, !op: stall_o = 0, err_o = 0, all registers hold.
- mem_ack_i outside REQ is ignored.

## Timing
- Reset values: DataMemReadData_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_be_o = 0, mem_wdata_o = 0. State is IDLE, counter and timeout flag are 0. stall_o and err_o read 0 after reset with op = 0.
- Latency, with cycle 0 being the IDLE cycle in which the op is presented:
  - mem_req_o is high from cycle 1.
  - If ack arrives in cycle N (N ≥ 1), DONE is cycle N+1.
  - The pipeline, including MEM_WB, advances at the end of cycle N+1.
  - Minimum: ack in cycle 1 gives 3 cycles per memory instruction, of which 2 are stalled.
- Timeout: the counter counts REQ cycles, and the abort happens in the REQ cycle where the count hits ACK_TIMEOUT with no ack. If ack arrives in that same cycle, the ack wins.
- Back-to-back memory ops: the next op is taken in the IDLE cycle that follows DONE. There is no bubble beyond DONE.
- start_i low in any state:
  - At the next edge, the FSM returns to IDLE and all registers take their reset values (mem_req_o drops).
  - stall_o is combinational, so it follows the state after that edge.

## Test plan
- LW at 0x100, store data don't-care, ack at cycle 1, mem_rdata_i = 0xDEADBEEF:
  - mem_addr_o = 0x100, mem_be_o = 1111.
  - DataMemReadData_o = 0xDEADBEEF in DONE.
  - stall_o high for exactly cycles 0–1.
- SB at 0x103, MemWriteData_i = 0x000000A5 → mem_we_o = 1, mem_be_o = 1000, mem_wdata_o = 0xA5A5A5A5, mem_addr_o = 0x100.
- LB / LBU / LHU with mem_rdata_i = 0x80F1_7F80:
  - LB at 0x100 → 0xFFFFFF80.
  - LBU at 0x101 → 0x0000007F.
  - LHU at 0x102 → 0x000080F1.
- LH at 0x101 (misaligned): err_o = 1, stall_o = 0, mem_req_o stays 0, DataMemReadData_o = 0. The same check applies to MemRead_i = MemWrite_i = 1.
- Load with ack withheld, ACK_TIMEOUT = 4:
  - mem_req_o is high for 4 cycles, then drops.
  - DONE shows err_o = 1, stall_o = 0, DataMemReadData_o = 0.
- start_i low in REQ with a 10-cycle ack delay:
  - Next edge: mem_req_o = 0, state IDLE, all outputs at reset values.
  - A later ack is ignored.
